data_memory_lsu: RTL and testbench

Parametrised data memory with a built-in load/store unit for the single-cycle/pipelined CPU datapath. It sits behind the ALU address output and accepts byte, half-word and word loads and stores with sign or zero extension. It checks alignment and range, and returns results through a fixed-latency, fully pipelined response path with an acknowledge strobe. It replaces the word-only data memory, keeps its rd/wr/cs request style, and adds an asynchronous reset for the response pipeline.

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/dmem_bank.sv | 49 ++++
 rtl/data_memory_lsu.sv | 136 +++++++++++++
 tb/tb_data_memory_lsu.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data memory / load-store unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Per-lane write enables for a store of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (sz)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicates right-justified store data so every candidate lane carries it;
    // the lane mask then picks which lanes actually get written.
    function automatic logic [31:0] store_align(size_e sz, logic [31:0] data);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{data[7:0]}};
            SZ_HALF: r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    // Extracts the addressed lane(s), right-justifies, then sign/zero extends.
    function automatic logic [31:0] load_extend(logic [31:0] word, size_e sz,
                                                logic uns, logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (sz)
            SZ_BYTE: r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with per-lane write enables and a registered read port.
// Contents come up as word i = i and are never touched by reset.
module dmem_bank #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [3:0]       we_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o
);

    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    mem_t        mem_q = mem_init();
    logic [31:0] rdata_q;

    // Byte-lane writes; lanes without an enable keep their old contents.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i[l]) begin
                mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
            end
        end
    end

    // Read register only moves on accepted loads so the load result holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_lsu.sv
// Data memory with load/store unit: request decode, alignment and range
// checks, lane steering, and a fixed-latency in-order ack/err pipeline.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr_ALU,
    input  logic [31:0]       rt_data,
    output logic [31:0]       data_out,
    output logic              ack,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    // One bit wider than the address so 4*DEPTH is representable even when
    // ADDR_W exactly covers the array.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH) << 2;

    size_e       sz;
    logic        req;
    logic        bad;
    logic        load_go;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] data_ld;

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] err_q, err_d;

    // Last load's extract/extend controls; lzero_q forces a zero result
    // after a rejected load and out of reset.
    logic        lzero_q;
    size_e       lsz_q;
    logic        luns_q;
    logic [1:0]  loff_q;

    // Request decode and rejection checks.
    always_comb begin
        sz      = size_e'(size);
        req     = cs & (rd | wr);
        bad     = (rd & wr)
                | (sz == SZ_ILL)
                | ((sz == SZ_HALF) & addr_ALU[0])
                | ((sz == SZ_WORD) & (|addr_ALU[1:0]))
                | ({1'b0, addr_ALU} >= ADDR_LIMIT);
        load_go = req & rd & ~bad;
        we      = (req & wr & ~bad) ? lane_mask(sz, addr_ALU[1:0]) : 4'b0000;
        wdata   = store_align(sz, rt_data);
    end

    dmem_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk_i   (clk),
        .rst_i   (rst),
        .idx_i   (addr_ALU[IDX_W+1:2]),
        .we_i    (we),
        .wdata_i (wdata),
        .re_i    (load_go),
        .rdata_o (rdata)
    );

    // Capture extend controls for every load request, accepted or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lzero_q <= 1'b1;
            lsz_q   <= SZ_WORD;
            luns_q  <= 1'b0;
            loff_q  <= 2'b00;
        end else if (req & rd) begin
            lzero_q <= bad;
            lsz_q   <= sz;
            luns_q  <= uns;
            loff_q  <= addr_ALU[1:0];
        end
    end

    assign data_ld = lzero_q ? 32'h0 : load_extend(rdata, lsz_q, luns_q, loff_q);

    // Next state of the valid/err shift pipeline.
    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = req;
        err_d[0] = req & bad;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    // Response pipeline; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    assign ack = vld_q[RD_LAT-1];
    assign err = err_q[RD_LAT-1];

    if (RD_LAT == 2) begin : g_lat2
        logic [31:0] dout_q;

        // data_ld only changes one edge before the matching ack, so an
        // unconditional register lines the result up with ack.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= data_ld;
            end
        end

        assign data_out = dout_q;
    end else begin : g_lat1
        assign data_out = data_ld;
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench: RD_LAT=1 and RD_LAT=2 instances share stimulus; a
// byte-wise reference model fills one scoreboard queue per instance.
module tb_data_memory_lsu;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, rd, wr, uns;
    logic [1:0]  size;
    logic [31:0] addr, rt;
    logic [31:0] dout1, dout2;
    logic        ack1, ack2, err1, err2;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q2[$];

    logic [7:0]  mb [4096];
    logic [31:0] cur_dout;
    logic        dout_known;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_lsu #(.DEPTH(1024), .RD_LAT(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .size(size), .uns(uns),
        .addr_ALU(addr), .rt_data(rt), .data_out(dout1), .ack(ack1), .err(err1)
    );

    data_memory_lsu #(.DEPTH(1024), .RD_LAT(2), .ADDR_W(32)) dut2 (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .size(size), .uns(uns),
        .addr_ALU(addr), .rt_data(rt), .data_out(dout2), .ack(ack2), .err(err2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mdl_load(logic [1:0] sz, logic u, logic [31:0] a);
        logic [11:0] b;
        logic [31:0] r;
        b = a[11:0];
        case (sz)
            2'd0:    r = u ? {24'h0, mb[b]} : {{24{mb[b][7]}}, mb[b]};
            2'd1:    r = u ? {16'h0, mb[b+1], mb[b]} : {{16{mb[b+1][7]}}, mb[b+1], mb[b]};
            default: r = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
        endcase
        return r;
    endfunction

    // Drives one request for one cycle and pushes its expected response.
    task automatic do_req(input logic r, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic bad;
        @(posedge clk);
        #2;
        cs = 1'b1; rd = r; wr = w; size = sz; uns = u; addr = a; rt = d;
        bad = (r & w) | (sz == 2'd3) | ((sz == 2'd1) & a[0]) |
              ((sz == 2'd2) & (a[1:0] != 2'b00)) | (a >= 32'h1000);
        if (w && !r && !bad) begin
            case (sz)
                2'd0: mb[a[11:0]] = d[7:0];
                2'd1: begin mb[a[11:0]] = d[7:0]; mb[a[11:0]+1] = d[15:8]; end
                default: for (int k = 0; k < 4; k++) mb[a[11:0]+k] = d[8*k +: 8];
            endcase
        end
        if (r && !w) begin
            cur_dout   = bad ? 32'h0 : mdl_load(sz, u, a);
            dout_known = 1'b1;
        end else if (r && w) begin
            dout_known = 1'b0;
        end
        e.err  = bad;
        e.chk  = dout_known;
        e.data = cur_dout;
        e.cyc  = cyc;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic do_nop(input logic c, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
        @(posedge clk);
        #2;
        cs = c; rd = r; wr = w; size = 2'd2; uns = 1'b0; addr = a; rt = d;
    endtask

    // Response monitors: pop in order, compare err, data and latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ack1) begin
            if (q1.size() == 0) begin
                check_val("ack1_unexpected", 32'(ack1), 32'h0);
            end else begin
                e = q1.pop_front();
                check_val("lat1", 32'(cyc - e.cyc), 32'd1);
                check_val("err1", 32'(err1), 32'(e.err));
                if (e.chk) check_val("dout1", dout1, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ack2) begin
            if (q2.size() == 0) begin
                check_val("ack2_unexpected", 32'(ack2), 32'h0);
            end else begin
                e = q2.pop_front();
                check_val("lat2", 32'(cyc - e.cyc), 32'd2);
                check_val("err2", 32'(err2), 32'(e.err));
                if (e.chk) check_val("dout2", dout2, e.data);
            end
        end
    end

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check_val({tag, "_ack1"}, 32'(ack1), 32'h0);
        check_val({tag, "_ack2"}, 32'(ack2), 32'h0);
        check_val({tag, "_err1"}, 32'(err1), 32'h0);
        check_val({tag, "_err2"}, 32'(err2), 32'h0);
        check_val({tag, "_dout1"}, dout1, 32'h0);
        check_val({tag, "_dout2"}, dout2, 32'h0);
    endtask

    initial begin
        logic [31:0] ra;
        logic        rr, rw;
        for (int i = 0; i < 1024; i++) begin
            for (int k = 0; k < 4; k++) mb[4*i+k] = 8'((i >> (8*k)) & 8'hFF);
        end
        cur_dout = 32'h0; dout_known = 1'b1;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'd0; uns = 1'b0;
        addr = 32'h0; rt = 32'h0;
        repeat (3) @(posedge clk);
        check_quiet("reset");
        @(posedge clk); #2; rst = 1'b0;

        do_req(1, 0, 2'd2, 0, 32'h10, 0);
        do_req(0, 1, 2'd0, 0, 32'h21, 32'h123456AB);
        do_req(1, 0, 2'd0, 0, 32'h21, 0);
        do_req(1, 0, 2'd0, 1, 32'h21, 0);
        do_req(1, 0, 2'd2, 0, 32'h20, 0);
        do_req(0, 1, 2'd1, 0, 32'h32, 32'h00008001);
        do_req(1, 0, 2'd1, 0, 32'h32, 0);
        do_req(1, 0, 2'd2, 0, 32'h30, 0);
        do_req(1, 0, 2'd1, 1, 32'h32, 0);

        do_req(1, 0, 2'd1, 0, 32'h03, 0);
        do_req(0, 1, 2'd2, 0, 32'h1000, 32'h55555555);
        do_req(1, 1, 2'd2, 0, 32'h10, 32'h66666666);
        do_req(0, 1, 2'd3, 0, 32'h14, 32'h77777777);
        do_req(0, 1, 2'd2, 0, 32'h16, 32'h88888888);
        do_req(1, 0, 2'd2, 0, 32'h14, 0);
        do_req(1, 0, 2'd2, 0, 32'h10, 0);
        do_req(1, 0, 2'd2, 0, 32'h0, 0);
        do_req(1, 0, 2'd2, 0, 32'hFFC, 0);

        do_nop(0, 0, 1, 32'h50, 32'h99999999);
        do_nop(1, 0, 0, 32'h50, 32'h99999999);
        do_req(1, 0, 2'd2, 0, 32'h50, 0);

        do_req(0, 1, 2'd2, 0, 32'h40, 32'hDEADBEEF);
        do_req(1, 0, 2'd2, 0, 32'h40, 0);

        for (int n = 0; n < 60; n++) begin
            ra = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) ra = ra | 32'h1000;
            rw = 1'($urandom_range(0, 1));
            rr = ~rw | ($urandom_range(0, 19) == 0);
            do_req(rr, rw, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom());
        end
        do_req(1, 0, 2'd2, 0, 32'h40, 0);

        do_req(1, 0, 2'd2, 0, 32'h44, 0);
        @(posedge clk); #2;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
        q1.delete(); q2.delete();
        cur_dout = 32'h0; dout_known = 1'b1;
        check_quiet("rst_pulse");
        @(posedge clk); #2; rst = 1'b0;
        repeat (3) check_quiet("post_rst");
        do_req(1, 0, 2'd2, 0, 32'h40, 0);
        do_req(0, 1, 2'd0, 0, 32'h43, 32'h0000007F);
        do_req(1, 0, 2'd0, 0, 32'h43, 0);

        do_nop(0, 0, 0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        check_val("drain_q1", 32'(q1.size()), 32'h0);
        check_val("drain_q2", 32'(q2.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
